// File: rtl/sub_bytes_seq_pkg.sv
// Shared AES definitions for the sequential S-box substitution engine.
// Holds the byte/word typedefs, the forward and inverse S-box tables and
// the engine's FSM state encoding.
package sub_bytes_seq_pkg;

    typedef logic [7:0]  aes_byte_t;
    typedef logic [31:0] aes_word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sub_bytes_seq_sbox_lane.sv
// One combinational S-box lane.
// Ports:
//   lhs  - input byte
//   inv  - 1 selects the inverse S-box (only when INV_EN=1)
//   o    - substituted byte
module sbox_lane
    import sub_bytes_seq_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [7:0] lhs,
    input  logic       inv,
    output logic [7:0] o
);

    generate
        if (INV_EN) begin : g_fwd_inv
            always_comb begin
                o = inv ? INV_SBOX[lhs] : SBOX[lhs];
            end
        end else begin : g_fwd_only
            // Inverse table is not built; the mode bit has no effect.
            logic unused_inv;
            assign unused_inv = inv;
            always_comb begin
                o = SBOX[lhs];
            end
        end
    endgenerate

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential S-box substitution engine: NUM_BYTES bytes per transaction,
// LANES S-box lanes time-multiplexed over NUM_BYTES/LANES beats, forward
// or inverse per transaction, valid/ready on both sides.
// Ports:
//   clk, rst             - clock (rising edge), synchronous active-low reset
//   in_valid/in_ready    - input handshake
//   in_data, in_inv      - bytes to substitute (byte i = bits [8i+7:8i]), mode
//   out_valid/out_ready  - output handshake
//   out_data             - substituted bytes, same ordering as in_data
module sub_bytes_seq
    import sub_bytes_seq_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 16,
    parameter int unsigned LANES     = 4,
    parameter bit          INV_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_BYTES*8-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_BYTES*8-1:0] out_data
);

    generate
        if (NUM_BYTES < 1 || LANES < 1 || (NUM_BYTES % LANES) != 0) begin : g_bad_params
            $error("sub_bytes_seq: NUM_BYTES must be >= 1 and a multiple of LANES");
        end
    endgenerate

    localparam int unsigned BEATS = NUM_BYTES / LANES;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IW    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    state_t          state, state_nxt;
    logic   [CW-1:0] cnt;
    logic            mode;
    logic            load;
    logic            beat;
    logic            last_beat;
    logic   [IW-1:0] base;
    aes_byte_t       src      [NUM_BYTES];
    aes_byte_t       res      [NUM_BYTES];
    aes_byte_t       lane_in  [LANES];
    aes_byte_t       lane_out [LANES];

    assign last_beat = (cnt == CW'(BEATS - 1));
    assign base      = IW'(int'(cnt) * LANES);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE with out_ready behaves like IDLE for the input side, so a new
    // transaction can be accepted in the same cycle the result is taken.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        beat      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                beat = 1'b1;
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load      = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            mode <= 1'b0;
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                src[i] <= '0;
                res[i] <= '0;
            end
        end else begin
            if (load) begin
                cnt  <= '0;
                mode <= INV_EN ? in_inv : 1'b0;
                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                    src[i] <= in_data[8*i +: 8];
                end
            end
            if (beat) begin
                cnt <= last_beat ? '0 : cnt + CW'(1);
                for (int unsigned k = 0; k < LANES; k++) begin
                    res[base + IW'(k)] <= lane_out[k];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_in[k] = src[base + IW'(k)];
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            sbox_lane #(.INV_EN(INV_EN)) u_lane (
                .lhs (lane_in[k]),
                .inv (mode),
                .o   (lane_out[k])
            );
        end
    endgenerate

    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            out_data[8*i +: 8] = res[i];
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
module tb_sub_bytes_seq;

    localparam logic [127:0] IDENT = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FWD   = 128'h76abd7fe2b670130c56f6bf27b777c63;

    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [127:0] in_data, out_data;

    logic         sw_valid, sw_ordy, ni_inv;
    logic [127:0] s16_d, s1_d, ni_d, s16_o, s1_o, ni_o;
    logic [31:0]  w4_d, w4_o;
    logic         s16_rdy, s1_rdy, w4_rdy, ni_rdy;
    logic         s16_v, s1_v, w4_v, ni_v;

    int checks;
    int errors;

    sub_bytes_seq #(.NUM_BYTES(16), .LANES(4), .INV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    sub_bytes_seq #(.NUM_BYTES(16), .LANES(16), .INV_EN(1'b1)) u_s16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s16_rdy),
        .in_data(s16_d), .in_inv(1'b0), .out_valid(s16_v),
        .out_ready(sw_ordy), .out_data(s16_o)
    );

    sub_bytes_seq #(.NUM_BYTES(16), .LANES(1), .INV_EN(1'b1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s1_rdy),
        .in_data(s1_d), .in_inv(1'b0), .out_valid(s1_v),
        .out_ready(sw_ordy), .out_data(s1_o)
    );

    sub_bytes_seq #(.NUM_BYTES(4), .LANES(4), .INV_EN(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(w4_rdy),
        .in_data(w4_d), .in_inv(1'b0), .out_valid(w4_v),
        .out_ready(sw_ordy), .out_data(w4_o)
    );

    sub_bytes_seq #(.NUM_BYTES(16), .LANES(4), .INV_EN(1'b0)) u_ni (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ni_rdy),
        .in_data(ni_d), .in_inv(ni_inv), .out_valid(ni_v),
        .out_ready(sw_ordy), .out_data(ni_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake one transaction into the main DUT, then scramble the inputs
    // so any late sampling of in_data/in_inv would corrupt the result.
    task automatic accept0(input logic [127:0] d, input logic inv);
        int n;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_inv   = ~inv;
    endtask

    task automatic wait_valid0(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic drain0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_forward;
        int lat;
        accept0(IDENT, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL fwd_busy_flags got in_ready=%b out_valid=%b exp=0/0", in_ready, out_valid);
        end
        wait_valid0(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL fwd_latency got=%0d exp=4", lat);
        end
        checks++;
        if (out_data !== FWD) begin
            errors++; $display("FAIL fwd_data got=%h exp=%h", out_data, FWD);
        end
        drain0();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL fwd_back_to_idle got out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_inverse;
        int lat;
        accept0(FWD, 1'b1);
        wait_valid0(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL inv_latency got=%0d exp=4", lat);
        end
        checks++;
        if (out_data !== IDENT) begin
            errors++; $display("FAIL inv_data got=%h exp=%h", out_data, IDENT);
        end
        drain0();
        accept0({16{8'h53}}, 1'b0);
        wait_valid0(lat);
        checks++;
        if (out_data !== {16{8'hed}}) begin
            errors++; $display("FAIL fwd_53 got=%h exp=%h", out_data, {16{8'hed}});
        end
        drain0();
        accept0({16{8'hed}}, 1'b1);
        wait_valid0(lat);
        checks++;
        if (out_data !== {16{8'h53}}) begin
            errors++; $display("FAIL inv_ed got=%h exp=%h", out_data, {16{8'h53}});
        end
        drain0();
    endtask

    task automatic test_back_to_back;
        int lat;
        accept0(IDENT, 1'b0);
        wait_valid0(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL bp_latency got=%0d exp=4", lat);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = {4{$urandom()}};
            in_inv   = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== FWD || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got out_valid=%b in_ready=%b data=%h exp=1/0 %h",
                         c, out_valid, in_ready, out_data, FWD);
            end
        end
        in_data   = {16{8'h53}};
        in_inv    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_through got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_no_idle got out_valid=%b in_ready=%b exp=0/0", out_valid, in_ready);
        end
        wait_valid0(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL bp_second_latency got=%0d exp=4", lat);
        end
        checks++;
        if (out_data !== {16{8'hed}}) begin
            errors++; $display("FAIL bp_second_data got=%h exp=%h", out_data, {16{8'hed}});
        end
        drain0();
    endtask

    task automatic test_reset_mid_busy;
        int  lat;
        logic seen;
        accept0(IDENT, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_busy_flags got out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL rst_busy_data got=%h exp=0", out_data);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_no_partial got=%b exp=0", seen);
        end
        accept0('0, 1'b0);
        wait_valid0(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL rst_after_latency got=%0d exp=4", lat);
        end
        checks++;
        if (out_data !== {16{8'h63}}) begin
            errors++; $display("FAIL rst_after_data got=%h exp=%h", out_data, {16{8'h63}});
        end
        drain0();
    endtask

    task automatic test_param_sweep;
        int l16, l1, l4, lni;
        checks++;
        if ({s16_rdy, s1_rdy, w4_rdy, ni_rdy} !== 4'b1111) begin
            errors++; $display("FAIL sweep_ready got=%b exp=1111", {s16_rdy, s1_rdy, w4_rdy, ni_rdy});
        end
        s16_d    = IDENT;
        s1_d     = IDENT;
        w4_d     = 32'h00010203;
        ni_d     = '0;
        ni_inv   = 1'b1;
        sw_valid = 1'b1;
        @(posedge clk); #1;
        sw_valid = 1'b0;
        s16_d    = '1;
        s1_d     = '1;
        w4_d     = '1;
        ni_d     = '1;
        l16 = 0; l1 = 0; l4 = 0; lni = 0;
        for (int c = 1; c <= 40; c++) begin
            if (s16_v === 1'b1 && l16 == 0) l16 = c - 1;
            if (s1_v  === 1'b1 && l1  == 0) l1  = c - 1;
            if (w4_v  === 1'b1 && l4  == 0) l4  = c - 1;
            if (ni_v  === 1'b1 && lni == 0) lni = c - 1;
            if (l16 != 0 && l1 != 0 && l4 != 0 && lni != 0) break;
            @(posedge clk); #1;
        end
        checks++;
        if (l16 != 1) begin
            errors++; $display("FAIL lanes16_latency got=%0d exp=1", l16);
        end
        checks++;
        if (s16_o !== FWD) begin
            errors++; $display("FAIL lanes16_data got=%h exp=%h", s16_o, FWD);
        end
        checks++;
        if (l1 != 16) begin
            errors++; $display("FAIL lanes1_latency got=%0d exp=16", l1);
        end
        checks++;
        if (s1_o !== FWD) begin
            errors++; $display("FAIL lanes1_data got=%h exp=%h", s1_o, FWD);
        end
        checks++;
        if (l4 != 1) begin
            errors++; $display("FAIL word_latency got=%0d exp=1", l4);
        end
        checks++;
        if (w4_o !== 32'h637c777b) begin
            errors++; $display("FAIL word_data got=%h exp=637c777b", w4_o);
        end
        checks++;
        if (lni != 4) begin
            errors++; $display("FAIL noinv_latency got=%0d exp=4", lni);
        end
        checks++;
        if (ni_o !== {16{8'h63}}) begin
            errors++; $display("FAIL noinv_data got=%h exp=%h", ni_o, {16{8'h63}});
        end
        sw_ordy = 1'b1;
        @(posedge clk); #1;
        sw_ordy = 1'b0;
        checks++;
        if ({s16_v, s1_v, w4_v, ni_v} !== 4'b0000) begin
            errors++; $display("FAIL sweep_drain got=%b exp=0000", {s16_v, s1_v, w4_v, ni_v});
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        sw_valid  = 1'b0;
        sw_ordy   = 1'b0;
        ni_inv    = 1'b0;
        s16_d     = '0;
        s1_d      = '0;
        w4_d      = '0;
        ni_d      = '0;
        @(posedge clk); #1;
        test_reset();
        test_forward();
        test_inverse();
        test_back_to_back();
        test_reset_mid_busy();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
